// File: rtl/rob_walk_ctrl.sv
// Rename-state recovery walk after a redirect: walks squashed ROB entries youngest-first, up to WALK_WIDTH per beat.
// First beat one cycle after the redirect; a beat holds stable while rat_ready_i is low; busy_o stalls rename until done.
module rob_walk_ctrl #(
   parameter int ROB_SIZE   = 64,
   parameter int WALK_WIDTH = 4,
   parameter int IDX_W      = $clog2(ROB_SIZE),
   parameter int NUM_W      = $clog2(WALK_WIDTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             redirect_en_i,
   input  logic [IDX_W:0]   redirect_idx_i,
   input  logic [IDX_W:0]   rob_tail_i,
   input  logic             rat_ready_i,
   output logic             walk_en_o,
   output logic [IDX_W:0]   walk_start_idx_o,
   output logic [NUM_W-1:0] walk_num_o,
   output logic             walk_done_o,
   output logic             busy_o
);
   localparam int PTR_W = IDX_W + 1;

   typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] walk_ptr_q, walk_ptr_d;
   logic [PTR_W-1:0] remaining_q, remaining_d;
   logic [NUM_W-1:0] beat_num;
   logic [PTR_W-1:0] ptr_after, rem_after, boundary, new_rem;

   function automatic logic is_older(input logic [PTR_W-1:0] a, input logic [PTR_W-1:0] b);
      if (a[PTR_W-1] == b[PTR_W-1]) return a[IDX_W-1:0] < b[IDX_W-1:0];
      return a[IDX_W-1:0] > b[IDX_W-1:0];
   endfunction

   assign beat_num = (remaining_q > PTR_W'(WALK_WIDTH)) ? NUM_W'(WALK_WIDTH)
                                                         : remaining_q[NUM_W-1:0];
   // Oldest squashed entry is one above this: the entry that caused the current walk.
   assign boundary = walk_ptr_q - PTR_W'(1) - remaining_q;

   always_comb begin
      state_d     = state_q;
      walk_ptr_d  = walk_ptr_q;
      remaining_d = remaining_q;
      ptr_after   = walk_ptr_q;
      rem_after   = remaining_q;
      new_rem     = '0;
      case (state_q)
         IDLE: begin
            if (redirect_en_i) begin
               new_rem     = rob_tail_i - redirect_idx_i - PTR_W'(1);
               walk_ptr_d  = rob_tail_i;
               remaining_d = new_rem;
               state_d     = (new_rem != '0) ? WALK : DONE;
            end
         end
         WALK: begin
            if (rat_ready_i) begin
               ptr_after = walk_ptr_q - PTR_W'(beat_num);
               rem_after = remaining_q - PTR_W'(beat_num);
            end
            walk_ptr_d  = ptr_after;
            remaining_d = rem_after;
            state_d     = (rem_after == '0) ? DONE : WALK;
            if (redirect_en_i && is_older(redirect_idx_i, boundary)) begin
               new_rem     = ptr_after - redirect_idx_i - PTR_W'(1);
               remaining_d = new_rem;
               state_d     = (new_rem == '0) ? DONE : WALK;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (redirect_en_i) begin
               new_rem     = walk_ptr_q - redirect_idx_i - PTR_W'(1);
               remaining_d = new_rem;
               state_d     = (new_rem != '0) ? WALK : DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         walk_ptr_q  <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         walk_ptr_q  <= walk_ptr_d;
         remaining_q <= remaining_d;
      end
   end

   assign walk_en_o        = (state_q == WALK);
   assign walk_start_idx_o = (state_q == WALK) ? walk_ptr_q - PTR_W'(1) : '0;
   assign walk_num_o       = (state_q == WALK) ? beat_num : '0;
   // A redirect landing in DONE restarts recovery, so completion is not announced.
   assign walk_done_o      = (state_q == DONE) && !redirect_en_i;
   assign busy_o           = (state_q != IDLE);
endmodule
